// File: rtl/vram_writer_if.sv
// Package and bus interface for vram_writer: job control, 4-bit pixel stream and masked
// 64-bit VRAM write port. `VRAM_WR_FLIP_EN adds the display-page flip signals.
package vram_writer_pkg;
  localparam logic [24:0] VRAM_PAGE1 = 25'h7A0000;
  localparam logic [24:0] VRAM_PAGE2 = 25'h7D0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_WRITE,
`ifdef VRAM_WR_FLIP_EN
    S_FLIP,
`endif
    S_DONE
  } state_t;
endpackage

interface vram_writer_if;
  logic        start;
  logic [21:0] start_addr;
  logic [18:0] pix_count;
  logic        busy;
  logic        done;
  logic        pix_valid;
  logic [3:0]  pix_data;
  logic        pix_ready;
  logic        mem_req;
  logic [21:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_ack;
`ifdef VRAM_WR_FLIP_EN
  logic        backtrace;
  logic [31:0] vram_start;
`endif

  modport master (
    output start, start_addr, pix_count, pix_valid, pix_data, mem_ack,
    input  busy, done, pix_ready, mem_req, mem_addr, mem_wdata, mem_wmask
`ifdef VRAM_WR_FLIP_EN
    , output backtrace, input vram_start
`endif
  );

  modport slave (
    input  start, start_addr, pix_count, pix_valid, pix_data, mem_ack,
    output busy, done, pix_ready, mem_req, mem_addr, mem_wdata, mem_wmask
`ifdef VRAM_WR_FLIP_EN
    , input backtrace, output vram_start
`endif
  );
endinterface

// File: rtl/vram_writer.sv
// Packs a 4-bit pixel stream 16-per-word and issues masked 64-bit VRAM writes.
// Optional `VRAM_WR_FLIP_EN: flip the displayed page in the vertical blank after the job.
module vram_writer #(
  parameter logic [24:0] VRAM_PAGE1 = vram_writer_pkg::VRAM_PAGE1
) (
  input  logic          clk,
  input  logic          reset_n,
  vram_writer_if.slave  bus
);
  import vram_writer_pkg::*;

  state_t      r_state;
  logic        r_busy;
  logic        r_done;
  logic        r_pix_ready;
  logic        r_mem_req;
  logic [21:0] r_mem_addr;
  logic [21:0] r_job_addr;
  logic [63:0] r_mem_wdata;
  logic [7:0]  r_mem_wmask;
  logic [3:0]  r_idx;
  logic [18:0] r_remaining;
`ifdef VRAM_WR_FLIP_EN
  logic [31:0] r_vram_start;
`endif

  // NOTE: all state is updated with non-blocking assignments so every branch sees
  // pre-edge values; blocking here would let r_idx/r_remaining race their own tests.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pix_ready  <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_job_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_wmask  <= '0;
      r_idx        <= '0;
      r_remaining  <= '0;
`ifdef VRAM_WR_FLIP_EN
      r_vram_start <= {7'b0, VRAM_PAGE1};
`endif
    end else begin
      // NOTE: done defaults low each cycle so it can only ever be a one-cycle pulse.
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_busy      <= 1'b1;
            r_mem_addr  <= bus.start_addr;
            r_job_addr  <= bus.start_addr;
            r_remaining <= bus.pix_count;
            r_idx       <= '0;
            if (bus.pix_count == '0) begin
              r_state <= S_DONE;
            end else begin
              r_state     <= S_FILL;
              r_pix_ready <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (bus.pix_valid) begin
            r_mem_wdata[{r_idx, 2'b00} +: 4] <= bus.pix_data;
            r_mem_wmask[r_idx[3:1]]          <= 1'b1;
            r_idx       <= r_idx + 4'd1;
            r_remaining <= r_remaining - 19'd1;
            // Last slot of the word or last pixel of the job: request on the next cycle.
            if (r_idx == 4'hF || r_remaining == 19'd1) begin
              r_state     <= S_WRITE;
              r_pix_ready <= 1'b0;
              r_mem_req   <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (bus.mem_ack) begin
            r_mem_req   <= 1'b0;
            r_mem_addr  <= r_mem_addr + 22'd1;
            r_mem_wdata <= '0;
            r_mem_wmask <= '0;
            r_idx       <= '0;
            if (r_remaining != '0) begin
              r_state     <= S_FILL;
              r_pix_ready <= 1'b1;
            end else begin
`ifdef VRAM_WR_FLIP_EN
              r_state <= S_FLIP;
`else
              r_state <= S_DONE;
`endif
            end
          end
        end
`ifdef VRAM_WR_FLIP_EN
        S_FLIP: begin
          if (bus.backtrace) begin
            r_vram_start <= {7'b0, r_job_addr, 3'b000};
            r_state      <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pix_ready = r_pix_ready;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_wmask = r_mem_wmask;
`ifdef VRAM_WR_FLIP_EN
  assign bus.vram_start = r_vram_start;
`endif
endmodule

// File: tb/tb_vram_writer.sv
// Directed self-checking bench for vram_writer; covers the page-flip path when
// built with `VRAM_WR_FLIP_EN.
module tb_vram_writer;
  localparam logic [63:0] PAGE1 = 64'h007A0000;
  localparam logic [63:0] PAGE2 = 64'h007D0000;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  vram_writer_if bus_if ();

  vram_writer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [21:0] addr, input logic [18:0] cnt);
    bus_if.start      = 1'b1;
    bus_if.start_addr = addr;
    bus_if.pix_count  = cnt;
    tick();
    bus_if.start = 1'b0;
    check("busy_after_start", bus_if.busy, 1'b1);
  endtask

  task automatic push(input logic [3:0] d);
    int w;
    bus_if.pix_valid = 1'b1;
    bus_if.pix_data  = d;
    w = 0;
    while (!bus_if.pix_ready && w < 20) begin
      tick();
      w++;
    end
    check("pix_ready_wait", bus_if.pix_ready, 1'b1);
    tick();
    bus_if.pix_valid = 1'b0;
  endtask

  task automatic push_ramp(input logic [3:0] first);
    for (int i = 0; i < 16; i++) push(first + 4'(i));
  endtask

  task automatic check_write(input string tag, input logic [21:0] addr,
                             input logic [63:0] wdata, input logic [7:0] wmask);
    check({tag, "_req"},   bus_if.mem_req, 1'b1);
    check({tag, "_addr"},  bus_if.mem_addr, addr);
    check({tag, "_wdata"}, bus_if.mem_wdata, wdata);
    check({tag, "_wmask"}, bus_if.mem_wmask, wmask);
    check({tag, "_ready"}, bus_if.pix_ready, 1'b0);
  endtask

  task automatic do_ack();
    bus_if.mem_ack = 1'b1;
    tick();
    bus_if.mem_ack = 1'b0;
    check("req_after_ack", bus_if.mem_req, 1'b0);
  endtask

  task automatic expect_done();
`ifdef VRAM_WR_FLIP_EN
    check("busy_in_flip", bus_if.busy, 1'b1);
    tick();
`endif
    check("done_not_early", bus_if.done, 1'b0);
    tick();
    check("done_pulse", bus_if.done, 1'b1);
    check("busy_clear", bus_if.busy, 1'b0);
    tick();
    check("done_single", bus_if.done, 1'b0);
  endtask

  initial begin
    bus_if.start      = 1'b0;
    bus_if.start_addr = '0;
    bus_if.pix_count  = '0;
    bus_if.pix_valid  = 1'b0;
    bus_if.pix_data   = '0;
    bus_if.mem_ack    = 1'b0;
`ifdef VRAM_WR_FLIP_EN
    bus_if.backtrace  = 1'b1;
`endif
    reset_n = 1'b0;
    tick();
    tick();
    check("rst_busy",  bus_if.busy, 1'b0);
    check("rst_done",  bus_if.done, 1'b0);
    check("rst_ready", bus_if.pix_ready, 1'b0);
    check("rst_req",   bus_if.mem_req, 1'b0);
    check("rst_addr",  bus_if.mem_addr, 22'h0);
    check("rst_wdata", bus_if.mem_wdata, 64'h0);
    check("rst_wmask", bus_if.mem_wmask, 8'h0);
`ifdef VRAM_WR_FLIP_EN
    check("rst_vram_start", bus_if.vram_start, PAGE1);
`endif
    reset_n = 1'b1;
    tick();

    // Full word, pixels 0..F, immediate ack.
    start_job(22'h0F4000, 19'd16);
    check("t1_ready", bus_if.pix_ready, 1'b1);
    push_ramp(4'h0);
    check_write("t1", 22'h0F4000, 64'hFEDCBA9876543210, 8'hFF);
    do_ack();
    expect_done();

    // Partial word: three pixels, high nibble of byte 1 written as zero.
    start_job(22'h000100, 19'd3);
    push(4'h1);
    push(4'h2);
    push(4'h3);
    check_write("t2", 22'h000100, 64'h321, 8'h03);
    do_ack();
    expect_done();

    // Delayed ack: write held stable, stray pixels and a second start ignored.
    start_job(22'h012340, 19'd16);
    for (int i = 0; i < 16; i++) push(4'hA);
    bus_if.pix_valid  = 1'b1;
    bus_if.pix_data   = 4'h3;
    bus_if.start      = 1'b1;
    bus_if.start_addr = 22'h000777;
    bus_if.pix_count  = 19'd5;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_write("t3_hold", 22'h012340, 64'hAAAAAAAAAAAAAAAA, 8'hFF);
    end
    bus_if.pix_valid = 1'b0;
    bus_if.start     = 1'b0;
    do_ack();
    expect_done();

    // Zero-length job: done without any request.
    start_job(22'h000200, 19'd0);
    check("t4_req_a", bus_if.mem_req, 1'b0);
    tick();
    check("t4_done", bus_if.done, 1'b1);
    check("t4_busy", bus_if.busy, 1'b0);
    check("t4_req_b", bus_if.mem_req, 1'b0);
    tick();
    check("t4_done_clear", bus_if.done, 1'b0);

    // Two words across the 22-bit address wrap.
    start_job(22'h3FFFFF, 19'd32);
    push_ramp(4'h1);
    check_write("t5_w0", 22'h3FFFFF, 64'h0FEDCBA987654321, 8'hFF);
    do_ack();
    check("t5_refill_ready", bus_if.pix_ready, 1'b1);
    check("t5_wrap_addr", bus_if.mem_addr, 22'h000000);
    check("t5_buf_clear", bus_if.mem_wdata, 64'h0);
    check("t5_mask_clear", bus_if.mem_wmask, 8'h0);
    check("t5_busy", bus_if.busy, 1'b1);
    push_ramp(4'h8);
    check_write("t5_w1", 22'h000000, 64'h76543210FEDCBA98, 8'hFF);
    do_ack();
    expect_done();

`ifdef VRAM_WR_FLIP_EN
    // Page flip waits for the vertical blank.
    bus_if.backtrace = 1'b0;
    start_job(22'h0FA000, 19'd16);
    push_ramp(4'h0);
    check_write("t6", 22'h0FA000, 64'hFEDCBA9876543210, 8'hFF);
    do_ack();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_wait_page", bus_if.vram_start, PAGE1);
      check("t6_wait_busy", bus_if.busy, 1'b1);
      check("t6_wait_done", bus_if.done, 1'b0);
    end
    bus_if.backtrace = 1'b1;
    tick();
    check("t6_flipped", bus_if.vram_start, PAGE2);
    tick();
    check("t6_done", bus_if.done, 1'b1);
    check("t6_busy", bus_if.busy, 1'b0);
    tick();
`endif

    // Reset asserted mid-write drops the request without waiting for a clock.
    start_job(22'h000400, 19'd16);
    push_ramp(4'h2);
    check("rw_req_up", bus_if.mem_req, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rw_req", bus_if.mem_req, 1'b0);
    check("rw_busy", bus_if.busy, 1'b0);
    check("rw_ready", bus_if.pix_ready, 1'b0);
`ifdef VRAM_WR_FLIP_EN
    check("rw_vram_start", bus_if.vram_start, PAGE1);
`endif
    tick();
    reset_n = 1'b1;
    tick();
    check("rw_idle_req", bus_if.mem_req, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end
endmodule
